// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB3 bus signals between a master and the register-file completer.
interface apb_slave_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pready;
   logic                  pslverr;
   logic [DATA_WIDTH-1:0] prdata;
   modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr, prdata);
   modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr, prdata);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer with a read-only ID register at index 0,
// read/write registers above it, and a fixed number of wait states per access.
module apb_slave_regfile #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter int                    WAIT_CYCLES = 2,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B3_0001
) (
   input logic               pclk,
   input logic               preset,
   apb_slave_regfile_if.slave apb
);
   localparam int RW = $clog2(NUM_REGS);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t                state, state_nx;
   logic [3:0]            cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [ADDR_WIDTH-3:0] idx;
   logic [RW-1:0]         ridx;
   logic                  done, err;
   assign idx  = apb.paddr[ADDR_WIDTH-1:2];
   assign ridx = idx[RW-1:0];
   assign done = state == ACCESS && apb.psel && apb.penable && cnt == 4'd0;
   assign err  = apb.paddr[1:0] != 2'b00 || idx >= (ADDR_WIDTH-2)'(NUM_REGS) || (apb.pwrite && idx == '0);
   assign apb.pready  = done;
   assign apb.pslverr = done && err;
   assign apb.prdata  = (done && !err && !apb.pwrite) ? (idx == '0 ? ID_VALUE : regs[ridx]) : '0;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == IDLE) begin
         state_nx = (apb.psel && !apb.penable) ? ACCESS : IDLE;
         cnt_nx   = (apb.psel && !apb.penable) ? 4'(WAIT_CYCLES) : cnt;
      end else if (!apb.psel || done) state_nx = IDLE;
      else if (apb.penable) cnt_nx = cnt - 4'd1;
   end
   always_ff @(posedge pclk or posedge preset)
      if (preset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   // Index 0 storage is never written; reads of it are replaced by ID_VALUE.
   always_ff @(posedge pclk or posedge preset)
      if (preset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (done && apb.pwrite && !err) regs[ridx] <= apb.pwdata;
endmodule
